// File: rtl/clk_en_bank_pkg.sv
// Shared types and constants for the clock-enable bank.
package clk_en_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    localparam int LOCK_SYNC_STAGES = 2;
    localparam int UNLOCK_CNT_W     = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [UNLOCK_CNT_W-1:0] sat_inc(input logic [UNLOCK_CNT_W-1:0] v);
        return (&v) ? v : v + UNLOCK_CNT_W'(1);
    endfunction

endpackage

// File: rtl/clk_en_bank_if.sv
// Configuration request bus: one channel update (ratio, phase) per transfer.
interface clk_en_bank_if #(
    parameter int NCH     = 5,
    parameter int RATIO_W = 10
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [CH_W-1:0]    cfg_ch;
    logic [RATIO_W-1:0] cfg_ratio;
    logic [RATIO_W-1:0] cfg_phase;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_ratio,
        output cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_ratio,
        input  cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/clk_en_bank_chan.sv
// One enable channel: period counter, ratio/phase registers and pulse decode.
module clk_en_chan #(
    parameter int RATIO_W   = 10,
    parameter int DEF_RATIO = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               active,
    input  logic               realign,
    input  logic               apply,
    input  logic [RATIO_W-1:0] new_ratio,
    input  logic [RATIO_W-1:0] new_phase,
    output logic               wrap,
    output logic               ce
);

    logic [RATIO_W-1:0] cnt;
    logic [RATIO_W-1:0] ratio;
    logic [RATIO_W-1:0] phase;
    logic [RATIO_W-1:0] phase_eff;

    // Ratios of 0 or 1 wrap every cycle so the channel is a constant enable.
    assign wrap = (ratio <= RATIO_W'(1)) || (cnt >= ratio - RATIO_W'(1));

    // Clamp the phase into the counter range so every ratio still pulses once per period.
    always_comb begin
        phase_eff = phase;
        if (ratio <= RATIO_W'(1)) begin
            phase_eff = '0;
        end else if (phase > ratio - RATIO_W'(1)) begin
            phase_eff = ratio - RATIO_W'(1);
        end
    end

    assign ce = active && (cnt == phase_eff);

    // New settings land only at a period boundary; otherwise count, or sit at 0 when not running.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            ratio <= RATIO_W'(DEF_RATIO);
            phase <= '0;
        end else if (apply) begin
            cnt   <= '0;
            ratio <= new_ratio;
            phase <= new_phase;
        end else if (!active || realign || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + RATIO_W'(1);
        end
    end

endmodule

// File: rtl/clk_en_bank.sv
// Bank of runtime-programmable clock enables, gated by a debounced PLL lock.
module clk_en_bank
    import clk_en_pkg::*;
#(
    parameter int NCH       = 5,
    parameter int RATIO_W   = 10,
    parameter int DEF_RATIO = 50,
    parameter int LOCK_HOLD = 1024
) (
    input  logic                    clkin1,
    input  logic                    pll_rst,
    input  logic                    pll_lock,
    input  logic                    resync,
    clk_en_bank_if.slave            cfg,
    output logic [NCH-1:0]          ce,
    output logic                    locked,
    output logic [UNLOCK_CNT_W-1:0] unlock_cnt
);

    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int HOLD_W = $clog2(LOCK_HOLD) + 1;
    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(NCH);

    logic [LOCK_SYNC_STAGES-1:0] sync_q;
    logic                        lock_s;
    state_t                      state, next_state;
    logic [HOLD_W-1:0]           hold_cnt, hold_next;

    logic               pend;
    logic [CH_W-1:0]    pend_ch;
    logic [RATIO_W-1:0] pend_ratio;
    logic [RATIO_W-1:0] pend_phase;

    logic               in_run, active, realign;
    logic               ch_ok, target_wrap, done;
    logic [NCH-1:0]     wrap;
    logic [NCH-1:0]     apply;

    // Bring the asynchronous lock indication into the clkin1 domain.
    always_ff @(posedge clkin1) begin
        if (pll_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[LOCK_SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

    // Lock qualification state and hold counter registers.
    always_ff @(posedge clkin1) begin
        if (pll_rst) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
        end else begin
            state    <= next_state;
            hold_cnt <= hold_next;
        end
    end

    // The WAIT_LOCK cycle that first sees lock counts as hold cycle 0, so RUN starts LOCK_HOLD cycles later.
    always_comb begin
        next_state = state;
        hold_next  = '0;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = STABLE;
                    hold_next  = HOLD_W'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                end else if (hold_cnt == HOLD_W'(LOCK_HOLD - 1)) begin
                    next_state = RUN;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                end
            end
            default: next_state = WAIT_LOCK;
        endcase
    end

    assign in_run  = (state == RUN);
    assign active  = in_run && lock_s;
    assign realign = in_run && resync;
    assign locked  = in_run;
    assign ch_ok   = ({1'b0, pend_ch} < CH_LIM);

    // Pick the target channel's wrap flag and steer the apply strobe to it alone.
    always_comb begin
        target_wrap = 1'b0;
        apply       = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pend_ch == CH_W'(i)) begin
                target_wrap = wrap[i];
                apply[i]    = done;
            end
        end
    end

    assign done = pend && (!ch_ok || !active || realign || target_wrap);

    // Single-entry config slot; out-of-range channels retire without touching any channel.
    always_ff @(posedge clkin1) begin
        if (pll_rst) begin
            pend       <= 1'b0;
            pend_ch    <= '0;
            pend_ratio <= '0;
            pend_phase <= '0;
        end else if (!pend && cfg.cfg_valid) begin
            pend       <= 1'b1;
            pend_ch    <= cfg.cfg_ch;
            pend_ratio <= cfg.cfg_ratio;
            pend_phase <= cfg.cfg_phase;
        end else if (done) begin
            pend <= 1'b0;
        end
    end

    assign cfg.cfg_ready = ~pend;

    // Count every lock loss seen while running, sticking at the top value.
    always_ff @(posedge clkin1) begin
        if (pll_rst) begin
            unlock_cnt <= '0;
        end else if (in_run && !lock_s) begin
            unlock_cnt <= sat_inc(unlock_cnt);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_en_chan #(
            .RATIO_W   (RATIO_W),
            .DEF_RATIO (DEF_RATIO)
        ) u_chan (
            .clk       (clkin1),
            .rst       (pll_rst),
            .active    (active),
            .realign   (realign),
            .apply     (apply[g]),
            .new_ratio (pend_ratio),
            .new_phase (pend_phase),
            .wrap      (wrap[g]),
            .ce        (ce[g])
        );
    end

endmodule

// File: tb/tb_clk_en_bank.sv
// Directed vector bench for clk_en_bank with LOCK_HOLD = 16.
module tb_clk_en_bank;

    typedef struct {
        int         phase;
        int         cyc;
        logic [4:0] ce;
        logic       lk;
        logic       rdy;
        logic [7:0] unl;
    } vec_t;

    logic       clkin1 = 1'b0;
    logic       pll_rst;
    logic       pll_lock;
    logic       resync;
    logic [4:0] ce;
    logic       locked;
    logic [7:0] unlock_cnt;

    int   cyc;
    int   checks;
    int   failures;
    vec_t vecs[$];

    clk_en_bank_if #(.NCH(5), .RATIO_W(10)) bus ();

    clk_en_bank #(
        .NCH       (5),
        .RATIO_W   (10),
        .DEF_RATIO (50),
        .LOCK_HOLD (16)
    ) dut (
        .clkin1     (clkin1),
        .pll_rst    (pll_rst),
        .pll_lock   (pll_lock),
        .resync     (resync),
        .cfg        (bus),
        .ce         (ce),
        .locked     (locked),
        .unlock_cnt (unlock_cnt)
    );

    always #5 clkin1 = ~clkin1;

    task automatic tick();
        @(posedge clkin1);
        #1;
        cyc++;
    endtask

    task automatic tickTo(input int n);
        while (cyc < n) tick();
    endtask

    task automatic compare(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic checkOutput(input logic [4:0] ce_exp, input logic lk_exp,
                               input logic rdy_exp, input logic [7:0] unl_exp);
        compare("ce", int'(ce), int'(ce_exp));
        compare("locked", int'(locked), int'(lk_exp));
        compare("cfg_ready", int'(bus.cfg_ready), int'(rdy_exp));
        compare("unlock_cnt", int'(unlock_cnt), int'(unl_exp));
    endtask

    task automatic applyStimulus(input logic [2:0] ch, input logic [9:0] ratio, input logic [9:0] phase);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch    = ch;
        bus.cfg_ratio = ratio;
        bus.cfg_phase = phase;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic addVec(input int p, input int c, input logic [4:0] e, input logic l,
                          input logic r, input logic [7:0] u);
        vec_t v;
        v.phase = p; v.cyc = c; v.ce = e; v.lk = l; v.rdy = r; v.unl = u;
        vecs.push_back(v);
    endtask

    task automatic runPhase(input int p);
        foreach (vecs[k]) begin
            if (vecs[k].phase == p) begin
                if (cyc > vecs[k].cyc) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL schedule cyc=%0d actual=%0d expected<=%0d", cyc, cyc, vecs[k].cyc);
                end else begin
                    tickTo(vecs[k].cyc);
                    checkOutput(vecs[k].ce, vecs[k].lk, vecs[k].rdy, vecs[k].unl);
                end
            end
        end
    endtask

    task automatic doReset();
        pll_rst  = 1'b1;
        pll_lock = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        pll_rst       = 1'b1;
        pll_lock      = 1'b0;
        resync        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_ratio = '0;
        bus.cfg_phase = '0;

        // phase 0: plain bring-up, lock driven in cycle 0
        addVec(0, 17, 5'h00, 0, 1, 0);
        addVec(0, 18, 5'h1f, 1, 1, 0);
        addVec(0, 19, 5'h00, 1, 1, 0);
        addVec(0, 67, 5'h00, 1, 1, 0);
        addVec(0, 68, 5'h1f, 1, 1, 0);
        // phase 1: bring-up after a one-cycle lock glitch
        addVec(1, 23, 5'h00, 0, 1, 0);
        addVec(1, 24, 5'h1f, 1, 1, 0);
        // phase 2: ch1 -> ratio 7 phase 3
        addVec(2, 35, 5'h00, 1, 0, 0);
        addVec(2, 72, 5'h00, 1, 0, 0);
        addVec(2, 73, 5'h00, 1, 0, 0);
        addVec(2, 74, 5'h1d, 1, 1, 0);
        addVec(2, 77, 5'h02, 1, 1, 0);
        // phase 3: ch2 -> ratio 1
        addVec(3, 81, 5'h00, 1, 0, 0);
        addVec(3, 123, 5'h00, 1, 0, 0);
        addVec(3, 124, 5'h1d, 1, 1, 0);
        addVec(3, 125, 5'h04, 1, 1, 0);
        addVec(3, 126, 5'h06, 1, 1, 0);
        // phase 4: ch3 -> ratio 4 phase 9
        addVec(4, 173, 5'h04, 1, 0, 0);
        addVec(4, 174, 5'h15, 1, 1, 0);
        addVec(4, 175, 5'h06, 1, 1, 0);
        addVec(4, 177, 5'h0c, 1, 1, 0);
        addVec(4, 181, 5'h0c, 1, 1, 0);
        addVec(4, 182, 5'h06, 1, 1, 0);
        // phase 5: out-of-range channel 7
        addVec(5, 183, 5'h04, 1, 0, 0);
        addVec(5, 184, 5'h04, 1, 1, 0);
        addVec(5, 224, 5'h17, 1, 1, 0);
        addVec(5, 225, 5'h0c, 1, 1, 0);
        // phase 6: ch2 -> ratio 8
        addVec(6, 227, 5'h04, 1, 0, 0);
        addVec(6, 228, 5'h04, 1, 1, 0);
        // phase 7: ch0 -> ratio 8, misaligned with ch2
        addVec(7, 273, 5'h0a, 1, 0, 0);
        addVec(7, 274, 5'h11, 1, 1, 0);
        addVec(7, 276, 5'h04, 1, 1, 0);
        // phase 8: after resync
        addVec(8, 279, 5'h15, 1, 1, 0);
        addVec(8, 282, 5'h0a, 1, 1, 0);
        addVec(8, 287, 5'h05, 1, 1, 0);
        // phase 9: lock loss in RUN
        addVec(9, 294, 5'h08, 1, 1, 0);
        addVec(9, 295, 5'h00, 1, 1, 0);
        addVec(9, 296, 5'h00, 0, 1, 1);

        $display("[TB] reset state");
        doReset();
        checkOutput(5'h00, 0, 1, 0);

        $display("[TB] lock bring-up");
        pll_rst  = 1'b0;
        pll_lock = 1'b1;
        cyc      = 0;
        runPhase(0);

        $display("[TB] reset from RUN, then lock glitch in STABLE");
        doReset();
        checkOutput(5'h00, 0, 1, 0);
        pll_rst  = 1'b0;
        pll_lock = 1'b1;
        cyc      = 0;
        tickTo(5);
        pll_lock = 1'b0;
        tickTo(6);
        pll_lock = 1'b1;
        runPhase(1);

        $display("[TB] reprogramming");
        tickTo(34);
        applyStimulus(3'd1, 10'd7, 10'd3);
        runPhase(2);
        tickTo(80);
        applyStimulus(3'd2, 10'd1, 10'd0);
        runPhase(3);
        tickTo(126);
        applyStimulus(3'd3, 10'd4, 10'd9);
        runPhase(4);
        tickTo(182);
        applyStimulus(3'd7, 10'd3, 10'd0);
        runPhase(5);
        tickTo(226);
        applyStimulus(3'd2, 10'd8, 10'd0);
        runPhase(6);
        applyStimulus(3'd0, 10'd8, 10'd0);
        runPhase(7);

        $display("[TB] resync");
        tickTo(278);
        resync = 1'b1;
        tick();
        resync = 1'b0;
        runPhase(8);

        $display("[TB] lock loss");
        tickTo(293);
        pll_lock = 1'b0;
        runPhase(9);

        for (int i = 2; i <= 256; i++) begin
            pll_lock = 1'b1;
            repeat (20) tick();
            if (i == 100 || i == 255 || i == 256) begin
                compare("locked_before_loss", int'(locked), 1);
            end
            pll_lock = 1'b0;
            repeat (4) tick();
            if (i == 100 || i == 255 || i == 256) begin
                compare("unlock_sat", int'(unlock_cnt), (i > 255) ? 255 : i);
            end
        end
        compare("ce_after_loss", int'(ce), 0);
        compare("locked_after_loss", int'(locked), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_en_bank.md
Name: clk_en_bank

Overview:
- Parametrised, runtime-reprogrammable bank of clock-enable generators in the PLL output/reference domain.
- Gates all enables on a debounced PLL lock.
- Successor to our fixed-ratio PLL wrappers. Adds per-channel dynamic ratio and phase, glitch-free reprogramming, lock qualification with an unlock counter, and a phase-aligned resync.
- Downstream logic uses the ce outputs instead of extra PLL outputs.

Parameters:
- NCH, 5: number of enable channels (1..16)
- RATIO_W, 10: width of the ratio and phase fields
- DEF_RATIO, 50: reset ratio for every channel
- LOCK_HOLD, 1024: cycles the synchronised lock must be stable high before enables start (≥2)

Ports:
- clkin1  in  1  sole clock
- pll_rst  in  1  reset, synchronous, active-high
- pll_lock  in  1  PLL lock, asynchronous to clkin1
- resync  in  1  one-cycle pulse; realigns all channel counters
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept
- cfg_ch  in  max(1,$clog2(NCH))  target channel
- cfg_ratio  in  RATIO_W  new ratio
- cfg_phase  in  RATIO_W  new phase
- ce  out  NCH  per-channel enable pulses
- locked  out  1  high while in RUN
- unlock_cnt  out  8  saturating count of lock losses seen in RUN

Behaviour:
- One clock (clkin1). Reset pll_rst is synchronous and active-high.
- Reset values:
  - ce = 0, locked = 0, unlock_cnt = 0, cfg_ready = 1
  - every channel: ratio = DEF_RATIO, phase = 0, cnt = 0
  - no update pending; state = WAIT_LOCK
- Lock synchroniser: lock_s = pll_lock through 2 flops (2-cycle latency).
- FSM:
  - WAIT_LOCK: hold_cnt = 0. Go to STABLE when lock_s = 1.
  - STABLE: hold_cnt increments each cycle. Go back to WAIT_LOCK if lock_s = 0. Go to RUN when hold_cnt = LOCK_HOLD-1. First RUN cycle is exactly LOCK_HOLD cycles after the first lock_s = 1.
  - RUN: go to WAIT_LOCK when lock_s = 0. In that same cycle ce is forced to 0 (ce decodes state), and unlock_cnt increments, saturating at 255.
- Counters:
  - All cnt are 0 on entry to RUN.
  - In RUN, cnt[i] counts 0..ratio[i]-1 and wraps.
  - Outside RUN, cnt = 0.
- Enable decode: ce[i] = (state == RUN) && (cnt[i] == phase_eff[i]).
  - phase_eff = min(phase, ratio-1).
  - ratio 0 or 1: ce[i] = 1 in every RUN cycle.
  - Decode uses registered values only; there is no combinational path from any input to ce.
  - Channels with equal ratio and phase are cycle-aligned.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready. It is captured into a single pending slot (ch, ratio, phase), and cfg_ready drops the next cycle.
  - In RUN, the pending update is applied in the cycle the target channel wraps (cnt = ratio-1, or any cycle if ratio ≤ 1). That channel's cnt then goes to 0 with the new values.
  - Outside RUN, the pending update is applied the cycle after capture.
  - cfg_ready returns to 1 the cycle after the apply.
  - cfg_ch ≥ NCH: accepted and discarded, with no change.
- resync:
  - In RUN, all cnt go to 0 the next cycle.
  - A pending update is applied in that same cycle.
  - Outside RUN, resync is ignored.
- Precedence: pll_rst > lock loss > resync > wrap/apply > count.
- Lock loss with an update pending: the update is applied on leaving RUN.
- Reset mid-update: the pending update is discarded.

Decomposition:
- Package clk_en_pkg holds:
  - FSM state enum {WAIT_LOCK, STABLE, RUN}
  - LOCK_SYNC_STAGES = 2
  - UNLOCK_CNT_W = 8
- Sub-module clk_en_chan, one instance per channel, holds cnt, ratio, phase, wrap, apply and ce decode.
- The top level holds the synchroniser, FSM, config slot and unlock counter.

Test Plan:
- Lock bring-up (LOCK_HOLD = 16): pll_lock rises at cycle 0 → locked = 1 and first ce[*] pulse at cycle 18. With DEF_RATIO = 50, ce[i] repeats every 50 cycles.
- Lock glitch: lock_s drops for 1 cycle in STABLE → hold count restarts. locked rises 16 cycles after lock_s returns high. unlock_cnt stays 0.
- Glitch-free reprogram: in RUN, program ch1 to ratio = 7, phase = 3 while its cnt = 10 → old period finishes, then pulses every 7 cycles at cnt = 3. cfg_ready stays low until the cycle after the apply.
- Edge ratios: ratio = 1 → ce high every RUN cycle. ratio = 4 with phase = 9 → pulse at cnt = 3. cfg_ch = 7 with NCH = 5 → no channel changes.
- Lock loss in RUN: pll_lock drops → ce = 0 exactly 2 cycles later, and unlock_cnt = 1. After 256 losses, unlock_cnt = 255.
- resync: ch0 and ch2 both at ratio = 8 with different phases of count → after a resync pulse, both cnt = 0 on the same cycle, and pulses are aligned thereafter.
